// File: rtl/bnn_img_loader_if.sv
// Signal bundle between the host byte front end and the BNN image loader.
// The loader takes the slave view; the host side (or a bench) takes the master view.
interface bnn_img_loader_if #(
    parameter int IMG_BITS = 904,
    parameter int BYTE_W   = 8,
    parameter int RESULT_W = 4
);
    logic [BYTE_W-1:0]   byte_in;
    logic                byte_valid;
    logic                byte_ready;
    logic                load_abort;
    logic [IMG_BITS-1:0] img_out;
    logic                img_buffer_full;
    logic                bnn_enable;
    logic [RESULT_W-1:0] result_in;
    logic                result_ready;
    logic                bnn_clear;
    logic [RESULT_W-1:0] result_data;
    logic                result_valid;
    logic                result_ack;
    logic                infer_timeout;

    modport master (
        output byte_in, byte_valid, load_abort, result_in, result_ready, result_ack,
        input  byte_ready, img_out, img_buffer_full, bnn_enable, bnn_clear,
               result_data, result_valid, infer_timeout
    );

    modport slave (
        input  byte_in, byte_valid, load_abort, result_in, result_ready, result_ack,
        output byte_ready, img_out, img_buffer_full, bnn_enable, bnn_clear,
               result_data, result_valid, infer_timeout
    );
endinterface

// File: rtl/bnn_img_loader.sv
// Packs host bytes MSB-first into the BNN image word, runs one inference,
// and hands the class result back to the host before re-arming the BNN.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_LOAD   | accepting image bytes, byte_ready=1
// S_INFER  | image frozen, bnn_enable=1, waiting for result_ready or timeout
// S_REPORT | result_valid held until host acks
// S_CLEAR  | bnn_clear pulsed, waiting for BNN to drop result_ready
module bnn_img_loader #(
    parameter int IMG_BITS       = 904,
    parameter int BYTE_W         = 8,
    parameter int RESULT_W       = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic             clk,
    input  logic             rst,
    bnn_img_loader_if.slave  bus
);
    localparam int NUM_BYTES = IMG_BITS / BYTE_W;
    localparam int CNT_W     = $clog2(NUM_BYTES);
    localparam int TMO_W     = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NUM_BYTES - 1);
    localparam logic [TMO_W-1:0] TMO_LOAD  = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {S_LOAD, S_INFER, S_REPORT, S_CLEAR} state_t;

    state_t              state;
    state_t              state_nxt;
    logic [CNT_W-1:0]    byte_cnt;
    logic [TMO_W-1:0]    tmo_cnt;
    logic [IMG_BITS-1:0] img_q;
    logic [RESULT_W-1:0] result_q;
    logic                result_valid_q;
    logic                timeout_q;
    logic                clear_q;

    logic byte_ready_c;
    logic busy_c;
    logic accept_c;
    logic last_c;
    logic tmo_hit_c;
    logic ack_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        byte_ready_c = 1'b0;
        busy_c       = 1'b0;
        accept_c     = 1'b0;
        last_c       = 1'b0;
        tmo_hit_c    = 1'b0;
        ack_c        = 1'b0;
        case (state)
            S_LOAD: begin
                byte_ready_c = 1'b1;
                // abort wins over a byte offered in the same cycle
                if (!bus.load_abort && bus.byte_valid) begin
                    accept_c = 1'b1;
                    if (byte_cnt == LAST_BYTE) begin
                        last_c    = 1'b1;
                        state_nxt = S_INFER;
                    end
                end
            end
            S_INFER: begin
                busy_c = 1'b1;
                if (bus.result_ready) begin
                    state_nxt = S_REPORT;
                end else if ((TIMEOUT_CYCLES != 0) && (tmo_cnt == '0)) begin
                    tmo_hit_c = 1'b1;
                    state_nxt = S_REPORT;
                end
            end
            S_REPORT: begin
                if (bus.result_ack) begin
                    ack_c     = 1'b1;
                    state_nxt = S_CLEAR;
                end
            end
            S_CLEAR: begin
                if (!bus.result_ready) begin
                    state_nxt = S_LOAD;
                end
            end
            default: state_nxt = S_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            byte_cnt       <= '0;
            tmo_cnt        <= '0;
            img_q          <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            timeout_q      <= 1'b0;
            clear_q        <= 1'b0;
        end else begin
            clear_q <= ack_c;
            if (state == S_LOAD && bus.load_abort) begin
                byte_cnt <= '0;
            end else if (accept_c) begin
                img_q[IMG_BITS-1 - BYTE_W*int'(byte_cnt) -: BYTE_W] <= bus.byte_in;
                byte_cnt <= last_c ? '0 : byte_cnt + CNT_W'(1);
                // timeout is a down-counter that expires on the zero-count INFER cycle
                if (last_c) begin
                    tmo_cnt <= TMO_LOAD;
                end
            end
            if (state == S_INFER) begin
                if (bus.result_ready) begin
                    result_q       <= bus.result_in;
                    result_valid_q <= 1'b1;
                    timeout_q      <= 1'b0;
                end else if (tmo_hit_c) begin
                    result_q       <= '1;
                    result_valid_q <= 1'b1;
                    timeout_q      <= 1'b1;
                end else begin
                    tmo_cnt <= tmo_cnt - TMO_W'(1);
                end
            end
            if (ack_c) begin
                result_valid_q <= 1'b0;
            end
        end
    end

    assign bus.byte_ready      = byte_ready_c;
    assign bus.img_out         = img_q;
    assign bus.img_buffer_full = busy_c;
    assign bus.bnn_enable      = busy_c;
    assign bus.bnn_clear       = clear_q;
    assign bus.result_data     = result_q;
    assign bus.result_valid    = result_valid_q;
    assign bus.infer_timeout   = timeout_q;
endmodule

// File: tb/tb_bnn_img_loader.sv
// Directed bench for bnn_img_loader: table of full load/infer/report transactions
// plus hand sequences for abort, continuous byte_valid, and mid-report reset.
module tb_bnn_img_loader;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    bnn_img_loader_if #(.IMG_BITS(904), .BYTE_W(8), .RESULT_W(4)) bus ();

    bnn_img_loader #(
        .IMG_BITS(904), .BYTE_W(8), .RESULT_W(4), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic [7:0] base;
        logic [7:0] stp;
        logic [3:0] res;
        int         delay;
        logic [7:0] exp_first;
        logic [7:0] exp_last;
        logic [3:0] exp_data;
        logic       exp_tmo;
        int         exp_cycles;
    } vec_t;

    vec_t vecs[5];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_img(input string name, input logic [903:0] exp);
        int bad;
        bad = -1;
        for (int k = 112; k >= 0; k--) begin
            if (bus.img_out[903-8*k -: 8] !== exp[903-8*k -: 8]) bad = k;
        end
        n_checks++;
        if (bad >= 0) begin
            n_errors++;
            $display("FAIL %s: byte %0d got %0h expected %0h", name, bad,
                     bus.img_out[903-8*bad -: 8], exp[903-8*bad -: 8]);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        logic [903:0] exp_img;
        logic [7:0]   b;
        int           cyc;
        bit           got;
        bit           rr;
        exp_img = '0;
        b = v.base;
        for (int k = 0; k < 113; k++) begin
            bus.byte_in    = b;
            bus.byte_valid = 1'b1;
            exp_img[903-8*k -: 8] = b;
            if (k == 112) chk($sformatf("v%0d_ready_before_last", idx), bus.byte_ready, 1);
            step();
            b = b + v.stp;
        end
        bus.byte_valid = 1'b0;
        chk($sformatf("v%0d_bnn_enable", idx), bus.bnn_enable, 1);
        chk($sformatf("v%0d_buf_full", idx), bus.img_buffer_full, 1);
        chk($sformatf("v%0d_ready_in_infer", idx), bus.byte_ready, 0);
        chk($sformatf("v%0d_first_byte", idx), bus.img_out[903:896], v.exp_first);
        chk($sformatf("v%0d_last_byte", idx), bus.img_out[7:0], v.exp_last);
        chk_img($sformatf("v%0d_image", idx), exp_img);

        cyc = 0;
        got = 1'b0;
        rr  = 1'b0;
        while (!got && cyc < 40) begin
            if (cyc == v.delay) begin
                bus.result_in    = v.res;
                bus.result_ready = 1'b1;
                rr = 1'b1;
            end
            cyc++;
            step();
            got = bus.result_valid;
        end
        chk($sformatf("v%0d_infer_cycles", idx), cyc, v.exp_cycles);
        chk($sformatf("v%0d_result_valid", idx), bus.result_valid, 1);
        chk($sformatf("v%0d_result_data", idx), bus.result_data, v.exp_data);
        chk($sformatf("v%0d_timeout", idx), bus.infer_timeout, v.exp_tmo);
        chk($sformatf("v%0d_enable_off", idx), bus.bnn_enable, 0);

        step();
        chk($sformatf("v%0d_valid_hold", idx), bus.result_valid, 1);
        chk($sformatf("v%0d_data_hold", idx), bus.result_data, v.exp_data);

        bus.result_ack = 1'b1;
        step();
        bus.result_ack = 1'b0;
        chk($sformatf("v%0d_clear_pulse", idx), bus.bnn_clear, 1);
        chk($sformatf("v%0d_valid_drop", idx), bus.result_valid, 0);
        chk($sformatf("v%0d_ready_in_clear", idx), bus.byte_ready, 0);
        if (rr) begin
            step();
            chk($sformatf("v%0d_clear_one_cycle", idx), bus.bnn_clear, 0);
            chk($sformatf("v%0d_clear_waits", idx), bus.byte_ready, 0);
            bus.result_ready = 1'b0;
        end
        step();
        chk($sformatf("v%0d_back_to_load", idx), bus.byte_ready, 1);
        chk($sformatf("v%0d_clear_low", idx), bus.bnn_clear, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int extra;
        int cyc;

        vecs[0] = '{base:8'h00, stp:8'h01, res:4'h7, delay:2,  exp_first:8'h00, exp_last:8'h70,
                    exp_data:4'h7, exp_tmo:1'b0, exp_cycles:3};
        vecs[1] = '{base:8'hFF, stp:8'hFF, res:4'h0, delay:0,  exp_first:8'hFF, exp_last:8'h8F,
                    exp_data:4'h0, exp_tmo:1'b0, exp_cycles:1};
        vecs[2] = '{base:8'h10, stp:8'h03, res:4'hA, delay:15, exp_first:8'h10, exp_last:8'h60,
                    exp_data:4'hA, exp_tmo:1'b0, exp_cycles:16};
        vecs[3] = '{base:8'hA5, stp:8'h00, res:4'h0, delay:99, exp_first:8'hA5, exp_last:8'hA5,
                    exp_data:4'hF, exp_tmo:1'b1, exp_cycles:16};
        vecs[4] = '{base:8'h01, stp:8'h02, res:4'h3, delay:1,  exp_first:8'h01, exp_last:8'hE1,
                    exp_data:4'h3, exp_tmo:1'b0, exp_cycles:2};

        bus.byte_in      = '0;
        bus.byte_valid   = 1'b0;
        bus.load_abort   = 1'b0;
        bus.result_in    = '0;
        bus.result_ready = 1'b0;
        bus.result_ack   = 1'b0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk("rst_byte_ready", bus.byte_ready, 1);
        chk("rst_buf_full", bus.img_buffer_full, 0);
        chk("rst_enable", bus.bnn_enable, 0);
        chk("rst_result_valid", bus.result_valid, 0);
        chk("rst_result_data", bus.result_data, 0);
        chk("rst_timeout", bus.infer_timeout, 0);
        chk("rst_clear", bus.bnn_clear, 0);
        chk("rst_img_zero", |bus.img_out, 0);

        // partial load then abort alongside byte 51
        for (int k = 0; k < 50; k++) begin
            bus.byte_in    = 8'hEE;
            bus.byte_valid = 1'b1;
            step();
        end
        bus.byte_in    = 8'h77;
        bus.load_abort = 1'b1;
        step();
        bus.load_abort = 1'b0;
        bus.byte_valid = 1'b0;
        chk("abort_still_load", bus.byte_ready, 1);
        chk("abort_no_enable", bus.bnn_enable, 0);

        for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

        // byte_valid held high: exactly one image worth of bytes accepted
        bus.byte_in    = 8'h3C;
        bus.byte_valid = 1'b1;
        acc = 0;
        for (int i = 0; i < 125; i++) begin
            if (bus.byte_ready) acc++;
            bus.load_abort = (i == 118);
            step();
        end
        bus.load_abort = 1'b0;
        chk("hold_bytes_accepted", acc, 113);
        chk("hold_abort_ignored", bus.bnn_enable, 1);
        extra = 0;
        cyc = 0;
        while (!bus.result_valid && cyc < 10) begin
            if (bus.byte_ready) extra++;
            cyc++;
            step();
        end
        chk("hold_timeout_valid", bus.result_valid, 1);
        if (bus.byte_ready) extra++;
        bus.result_ack = 1'b1;
        step();
        bus.result_ack = 1'b0;
        if (bus.byte_ready) extra++;
        step();
        bus.byte_valid = 1'b0;
        chk("hold_no_extra_bytes", extra, 0);
        chk("hold_back_to_load", bus.byte_ready, 1);

        // reset while a timed-out result is pending
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int k = 0; k < 113; k++) begin
            bus.byte_in    = 8'h5A;
            bus.byte_valid = 1'b1;
            step();
        end
        bus.byte_valid = 1'b0;
        cyc = 0;
        while (!bus.result_valid && cyc < 20) begin
            cyc++;
            step();
        end
        chk("pre_rst_valid", bus.result_valid, 1);
        chk("pre_rst_timeout", bus.infer_timeout, 1);
        chk("pre_rst_img", bus.img_out[903:896], 8'h5A);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_valid", bus.result_valid, 0);
        chk("mid_rst_byte_ready", bus.byte_ready, 1);
        chk("mid_rst_img_zero", |bus.img_out, 0);
        chk("mid_rst_timeout", bus.infer_timeout, 0);
        chk("mid_rst_data", bus.result_data, 0);
        chk("mid_rst_enable", bus.bnn_enable, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
